// File: rtl/ysyx_22050710_sram_arbiter.sv
// Two-master (fetch, execute) to one-slave arbiter for the SRAM-like memory port.
// Source of every accepted request is queued in order so responses route back to their issuer.
module ysyx_22050710_sram_arbiter #(
    parameter int SRAM_ADDR_WD  = 32,
    parameter int SRAM_DATA_WD  = 64,
    parameter int SRAM_WMASK_WD = 8,
    parameter int OUTSTANDING   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,

    input  logic                     i_inst_req,
    input  logic [SRAM_ADDR_WD-1:0]  i_inst_addr,
    output logic                     o_inst_addr_ok,
    output logic                     o_inst_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_inst_rdata,

    input  logic                     i_data_req,
    input  logic                     i_data_op,
    input  logic [1:0]               i_data_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_data_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_data_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_data_wdata,
    output logic                     o_data_addr_ok,
    output logic                     o_data_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_data_rdata,

    output logic                     o_mem_req,
    output logic                     o_mem_op,
    output logic [1:0]               o_mem_size,
    output logic [SRAM_ADDR_WD-1:0]  o_mem_addr,
    output logic [SRAM_WMASK_WD-1:0] o_mem_wstrb,
    output logic [SRAM_DATA_WD-1:0]  o_mem_wdata,
    input  logic                     i_mem_addr_ok,
    input  logic                     i_mem_data_ok,
    input  logic [SRAM_DATA_WD-1:0]  i_mem_rdata
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);

    logic             lock_q, lock_d;
    logic             lock_sel_q, lock_sel_d;
    logic             src_q [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic grant_data;
    logic grant_req;
    logic accepted;
    logic pop;
    logic head_data;

    // A stalled request keeps its grant until the slave takes it.
    always_comb begin
        grant_data = lock_q ? lock_sel_q : i_data_req;
        grant_req  = grant_data ? i_data_req : i_inst_req;
        o_mem_req  = grant_req && (count_q < CNT_MAX);
        accepted   = o_mem_req && i_mem_addr_ok;

        o_mem_op    = 1'b0;
        o_mem_size  = 2'd0;
        o_mem_addr  = '0;
        o_mem_wstrb = '0;
        o_mem_wdata = '0;
        if (o_mem_req) begin
            if (grant_data) begin
                o_mem_op    = i_data_op;
                o_mem_size  = i_data_size;
                o_mem_addr  = i_data_addr;
                o_mem_wstrb = i_data_wstrb;
                o_mem_wdata = i_data_wdata;
            end else begin
                o_mem_size  = 2'd3;
                o_mem_addr  = i_inst_addr;
            end
        end

        o_data_addr_ok = accepted && grant_data;
        o_inst_addr_ok = accepted && !grant_data;
    end

    // Responses with nothing outstanding are dropped without touching state.
    always_comb begin
        pop            = i_mem_data_ok && (count_q != '0);
        head_data      = src_q[rd_ptr_q];
        o_data_data_ok = pop && head_data;
        o_inst_data_ok = pop && !head_data;
        o_data_rdata   = o_data_data_ok ? i_mem_rdata : '0;
        o_inst_rdata   = o_inst_data_ok ? i_mem_rdata : '0;
    end

    always_comb begin
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (accepted) begin
            lock_d = 1'b0;
        end else if (o_mem_req) begin
            lock_d     = 1'b1;
            lock_sel_d = grant_data;
        end

        wr_ptr_d = wr_ptr_q;
        if (accepted) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (accepted && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !accepted) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entries are only read while counted as valid, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (accepted) begin
            src_q[wr_ptr_q] <= grant_data;
        end
    end

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Directed bench for the SRAM arbiter; the bench plays the memory slave by hand.
module tb_ysyx_22050710_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [63:0] inst_rdata;
    logic        data_req, data_op;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [7:0]  data_wstrb;
    logic [63:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [63:0] data_rdata;
    logic        mem_req, mem_op;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [63:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22050710_sram_arbiter dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_inst_req     (inst_req),
        .i_inst_addr    (inst_addr),
        .o_inst_addr_ok (inst_addr_ok),
        .o_inst_data_ok (inst_data_ok),
        .o_inst_rdata   (inst_rdata),
        .i_data_req     (data_req),
        .i_data_op      (data_op),
        .i_data_size    (data_size),
        .i_data_addr    (data_addr),
        .i_data_wstrb   (data_wstrb),
        .i_data_wdata   (data_wdata),
        .o_data_addr_ok (data_addr_ok),
        .o_data_data_ok (data_data_ok),
        .o_data_rdata   (data_rdata),
        .o_mem_req      (mem_req),
        .o_mem_op       (mem_op),
        .o_mem_size     (mem_size),
        .o_mem_addr     (mem_addr),
        .o_mem_wstrb    (mem_wstrb),
        .o_mem_wdata    (mem_wdata),
        .i_mem_addr_ok  (mem_addr_ok),
        .i_mem_data_ok  (mem_data_ok),
        .i_mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; inst_req = 0; inst_addr = '0;
        data_req = 0; data_op = 0; data_size = '0; data_addr = '0; data_wstrb = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
        next(); next();
        rst = 1'b0;

        // reset state
        sample();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        next();

        // single fetch
        inst_req = 1; inst_addr = 32'h8000_0000;
        sample();
        chk("f_mem_req", mem_req, 1);
        chk("f_mem_addr", mem_addr, 64'h8000_0000);
        chk("f_mem_size", mem_size, 3);
        chk("f_mem_op", mem_op, 0);
        chk("f_addr_ok_wait", inst_addr_ok, 0);
        next();
        mem_addr_ok = 1;
        sample();
        chk("f_addr_ok", inst_addr_ok, 1);
        chk("f_data_addr_ok", data_addr_ok, 0);
        next();
        inst_req = 0; mem_addr_ok = 0;
        sample();
        chk("f_idle_req", mem_req, 0);
        chk("f_idle_addr_ok", inst_addr_ok, 0);
        next();
        mem_data_ok = 1; mem_rdata = 64'h13;
        sample();
        chk("f_data_ok", inst_data_ok, 1);
        chk("f_rdata", inst_rdata, 64'h13);
        chk("f_d_data_ok", data_data_ok, 0);
        chk("f_d_rdata", data_rdata, 0);
        next();
        mem_data_ok = 0;
        sample();
        chk("f_data_ok_off", inst_data_ok, 0);
        next();

        // simultaneous requests: data first, then inst; responses route D then I
        inst_req = 1; inst_addr = 32'h8000_0004;
        data_req = 1; data_op = 0; data_size = 3; data_addr = 32'h8000_1000;
        mem_addr_ok = 1;
        sample();
        chk("s_data_addr_ok", data_addr_ok, 1);
        chk("s_inst_addr_ok0", inst_addr_ok, 0);
        chk("s_mem_addr_d", mem_addr, 64'h8000_1000);
        next();
        data_req = 0;
        sample();
        chk("s_inst_addr_ok", inst_addr_ok, 1);
        chk("s_mem_addr_i", mem_addr, 64'h8000_0004);
        next();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 64'hAAAA;
        sample();
        chk("s_resp_d", data_data_ok, 1);
        chk("s_resp_d_rdata", data_rdata, 64'hAAAA);
        chk("s_resp_d_inst", inst_data_ok, 0);
        next();
        mem_rdata = 64'hBBBB;
        sample();
        chk("s_resp_i", inst_data_ok, 1);
        chk("s_resp_i_rdata", inst_rdata, 64'hBBBB);
        chk("s_resp_i_data", data_data_ok, 0);
        next();
        mem_data_ok = 0;

        // lock: stalled inst keeps grant against an arriving store
        inst_req = 1; inst_addr = 32'h8000_0008;
        sample();
        chk("l_addr0", mem_addr, 64'h8000_0008);
        next();
        data_req = 1; data_op = 1; data_size = 1; data_addr = 32'h8000_2000;
        data_wstrb = 8'hFF; data_wdata = 64'hDEAD_BEEF;
        sample();
        chk("l_addr1", mem_addr, 64'h8000_0008);
        chk("l_op1", mem_op, 0);
        chk("l_size1", mem_size, 3);
        chk("l_wstrb1", mem_wstrb, 0);
        chk("l_wdata1", mem_wdata, 0);
        chk("l_d_addr_ok1", data_addr_ok, 0);
        next();
        sample();
        chk("l_addr2", mem_addr, 64'h8000_0008);
        next();
        mem_addr_ok = 1;
        sample();
        chk("l_inst_acc", inst_addr_ok, 1);
        chk("l_data_blk", data_addr_ok, 0);
        next();
        inst_req = 0;
        sample();
        chk("l_data_acc", data_addr_ok, 1);
        chk("l_data_addr", mem_addr, 64'h8000_2000);
        next();

        // full FIFO (I, D outstanding): third request blocked even with a same-cycle pop
        data_req = 0; inst_req = 1; inst_addr = 32'h8000_000C;
        sample();
        chk("full_req", mem_req, 0);
        chk("full_addr_ok", inst_addr_ok, 0);
        next();
        mem_data_ok = 1; mem_rdata = 64'h11;
        sample();
        chk("full_pop_i", inst_data_ok, 1);
        chk("full_pop_rdata", inst_rdata, 64'h11);
        chk("full_pop_req", mem_req, 0);
        chk("full_pop_addr_ok", inst_addr_ok, 0);
        next();
        mem_data_ok = 0;
        sample();
        chk("full_after_req", mem_req, 1);
        chk("full_after_acc", inst_addr_ok, 1);
        next();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 64'h22;
        sample();
        chk("full_drain_d", data_data_ok, 1);
        chk("full_drain_d_rdata", data_rdata, 64'h22);
        next();
        mem_rdata = 64'h33;
        sample();
        chk("full_drain_i", inst_data_ok, 1);
        chk("full_drain_i_d", data_data_ok, 0);
        next();
        mem_data_ok = 0;

        // store pass-through
        data_req = 1; data_op = 1; data_size = 2; data_addr = 32'h8000_3000;
        data_wstrb = 8'h0F; data_wdata = 64'h1234; mem_addr_ok = 1;
        sample();
        chk("st_op", mem_op, 1);
        chk("st_size", mem_size, 2);
        chk("st_wstrb", mem_wstrb, 64'h0F);
        chk("st_wdata", mem_wdata, 64'h1234);
        chk("st_addr", mem_addr, 64'h8000_3000);
        chk("st_acc", data_addr_ok, 1);
        next();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = '0;
        sample();
        chk("st_data_ok", data_data_ok, 1);
        chk("st_inst_ok", inst_data_ok, 0);
        next();

        // stray response with empty FIFO
        mem_rdata = 64'h55;
        sample();
        chk("stray_i", inst_data_ok, 0);
        chk("stray_d", data_data_ok, 0);
        chk("stray_rdata", inst_rdata, 0);
        next();
        mem_data_ok = 0;

        // reset with two outstanding
        inst_req = 1; inst_addr = 32'h8000_0010; mem_addr_ok = 1;
        next(); next();
        sample();
        chk("pre_rst_full", mem_req, 0);
        next();
        inst_req = 0; mem_addr_ok = 0; rst = 1;
        next();
        rst = 0; mem_data_ok = 1; mem_rdata = 64'h66;
        sample();
        chk("post_rst_stray_i", inst_data_ok, 0);
        chk("post_rst_stray_d", data_data_ok, 0);
        next();
        mem_data_ok = 0; inst_req = 1; mem_addr_ok = 1;
        sample();
        chk("post_rst_acc0", inst_addr_ok, 1);
        next();
        sample();
        chk("post_rst_acc1", inst_addr_ok, 1);
        next();
        sample();
        chk("post_rst_full", mem_req, 0);
        next();

        // reset clears a held lock
        inst_req = 0; rst = 1;
        next();
        rst = 0; inst_req = 1; inst_addr = 32'h8000_0020; mem_addr_ok = 0;
        next();
        rst = 1;
        next();
        rst = 0; data_req = 1; data_op = 0; data_addr = 32'h8000_4000;
        sample();
        chk("rst_lock_addr", mem_addr, 64'h8000_4000);
        chk("rst_lock_op", mem_op, 0);
        next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_sram_arbiter.md
Name: ysyx_22050710_sram_arbiter

Overview:
- Two-master to one-slave arbiter for the core's SRAM-like memory interface.
- Shares one memory port between the fetch stage (instruction reads) and the execute stage (data loads and stores).
- Accepts requests on the req/addr_ok handshake and returns responses in order on data_ok.
- Records the source of every accepted transaction in an in-order ID FIFO, so each response is routed back to the master that issued it.

Parameters:
- SRAM_ADDR_WD, 32, address width.
- SRAM_DATA_WD, 64, read/write data width.
- SRAM_WMASK_WD, 8, write byte-strobe width (SRAM_DATA_WD/8).
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions; power of two, at least 1.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_inst_req  in  1  fetch read request.
- i_inst_addr  in  SRAM_ADDR_WD  fetch address.
- o_inst_addr_ok  out  1  fetch request accepted this cycle.
- o_inst_data_ok  out  1  fetch read data valid this cycle.
- o_inst_rdata  out  SRAM_DATA_WD  fetch read data.
- i_data_req  in  1  data request.
- i_data_op  in  1  1 = write, 0 = read.
- i_data_size  in  2  0/1/2/3 = 1/2/4/8 bytes.
- i_data_addr  in  SRAM_ADDR_WD  data address.
- i_data_wstrb  in  SRAM_WMASK_WD  write byte enables.
- i_data_wdata  in  SRAM_DATA_WD  write data.
- o_data_addr_ok  out  1  data request accepted this cycle.
- o_data_data_ok  out  1  data response this cycle (read data, or write acknowledge).
- o_data_rdata  out  SRAM_DATA_WD  data read data.
- o_mem_req  out  1  request to the memory slave.
- o_mem_op  out  1  request type; 1 = write, 0 = read.
- o_mem_size  out  2  request size.
- o_mem_addr  out  SRAM_ADDR_WD  request address.
- o_mem_wstrb  out  SRAM_WMASK_WD  write byte enables.
- o_mem_wdata  out  SRAM_DATA_WD  write data.
- i_mem_addr_ok  in  1  slave accepted the request.
- i_mem_data_ok  in  1  slave response valid.
- i_mem_rdata  in  SRAM_DATA_WD  slave read data.

Behaviour:
- Reset (i_rst=1 at a clock edge): ID FIFO empty; count = 0; lock = 0. All outputs are 0 while the FIFO is empty and no master requests.
- Grant, fixed priority: data wins over inst.
- Lock: once o_mem_req=1 with i_mem_addr_ok=0, a lock register holds the current grant until the cycle in which i_mem_addr_ok=1. A lower- or higher-priority request arriving meanwhile does not steal the grant. Masters hold their request fields stable until they see addr_ok.
- Inst requests drive o_mem_op=0, o_mem_size=3, o_mem_wstrb=0, o_mem_wdata=0.
- Data requests pass all their fields through unchanged.
- Back-pressure: o_mem_req = (granted master's req) && (count < OUTSTANDING). When the FIFO is full, no request is issued, even if data_ok pops in the same cycle.
- Acceptance: accepted = o_mem_req && i_mem_addr_ok. This is the only condition that:
  - asserts the granted master's addr_ok (combinational, same cycle);
  - pushes the source bit (1 = data, 0 = inst) into the FIFO.
- Response: i_mem_data_ok pops the FIFO head. If head = data, then o_data_data_ok=1 and o_data_rdata=i_mem_rdata; otherwise the same applies to the inst side. Both are combinational, zero added latency.
- Non-selected response outputs are 0.
- Stores also receive data_ok.
- Push and pop in the same cycle: count is unchanged and FIFO pointers advance correctly; a same-cycle push and pop with the FIFO empty beforehand is not allowed.
- i_mem_data_ok while the FIFO is empty is ignored: no data_ok output, no state change.
- Pointers are log2(OUTSTANDING) bits and wrap modulo OUTSTANDING. Count is log2(OUTSTANDING)+1 bits.
- Responses are strictly in order; no reordering.
- Reset mid-transaction: the FIFO is discarded and the lock is cleared. Any later stray data_ok is ignored under the empty-FIFO rule.

Test Plan:
- Single fetch: inst_req, addr 0x80000000, addr_ok next cycle, data_ok 2 cycles later with rdata 0x13 -> o_inst_addr_ok one cycle; o_inst_data_ok with rdata 0x13; data side stays 0.
- Simultaneous requests: both reqs and addr_ok=1 continuously -> data accepted first, inst in the next cycle; responses D then I route to data then inst.
- Lock: inst_req issued, addr_ok held 0 for 3 cycles, data_req arrives in cycle 1 -> o_mem_addr stays the inst address until accept; data accepted afterwards.
- Full FIFO (OUTSTANDING=2): two reads accepted, no data_ok -> third request gives o_mem_req=0. Same-cycle data_ok still blocks it; it is accepted the following cycle.
- Store: data_op=1, size=2, wstrb=0x0F, wdata=0x1234 -> fields pass through; later data_ok asserts o_data_data_ok.
- Stray/reset: data_ok with an empty FIFO -> no outputs. Assert i_rst with 2 outstanding -> count = 0; a subsequent data_ok is ignored.
